// File: rtl/lcd_pkg.sv
// Shared constants and state encoding for the LCD1602 refresh path.
package lcd_pkg;

    localparam logic [7:0] LCD_CMD_LINE0 = 8'h80;
    localparam logic [7:0] LCD_CMD_LINE1 = 8'hC0;
    localparam logic [7:0] LCD_SPACE     = 8'h20;

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        GAP
    } lcd_state_e;

endpackage

// File: rtl/lcd_refresh_ctrl_if.sv
// Byte-request handshake between the refresh scheduler (master) and the byte-write engine (slave).
interface lcd_refresh_ctrl_if;

    logic       ena_write;
    logic [7:0] data;
    logic       cmd_data;
    logic       done_write;

    modport master (
        output ena_write,
        output data,
        output cmd_data,
        input  done_write
    );

    modport slave (
        input  ena_write,
        input  data,
        input  cmd_data,
        output done_write
    );

endinterface

// File: rtl/lcd_char_buffer.sv
// 2 x COLS character shadow buffer: one write port, one combinational read port.
// Resets and clears to spaces.
module lcd_char_buffer
    import lcd_pkg::*;
#(
    parameter  int COLS = 16,
    localparam int CW   = $clog2(COLS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          we,
    input  logic          we_line,
    input  logic [CW-1:0] we_col,
    input  logic [7:0]    we_char,
    input  logic          rd_line,
    input  logic [CW-1:0] rd_col,
    output logic [7:0]    rd_char
);

    logic [7:0] mem [2][COLS];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int l = 0; l < 2; l++) begin
                for (int c = 0; c < COLS; c++) begin
                    mem[l][c] <= LCD_SPACE;
                end
            end
        end else if (clear) begin
            for (int l = 0; l < 2; l++) begin
                for (int c = 0; c < COLS; c++) begin
                    mem[l][c] <= LCD_SPACE;
                end
            end
        end else if (we) begin
            mem[we_line][we_col] <= we_char;
        end
    end

    assign rd_char = mem[rd_line][rd_col];

endmodule

// File: rtl/lcd_refresh_ctrl.sv
// Display-refresh scheduler: streams each dirty line to the byte-write engine as one
// DDRAM address command plus COLS data bytes. Define LCD_REFRESH_RR_EN for round-robin line choice.
//
// state | meaning
// IDLE  | waiting for init_done and a dirty line
// SEND  | ena_write high, byte idx held until done_write
// GAP   | one idle cycle between bytes, then next byte or back to IDLE
module lcd_refresh_ctrl
    import lcd_pkg::*;
#(
    parameter  int COLS = 16,
    localparam int CW   = $clog2(COLS),
    localparam int IW   = $clog2(COLS + 2)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               init_done,
    input  logic               wr_en,
    input  logic               wr_line,
    input  logic [CW-1:0]      wr_col,
    input  logic [7:0]         wr_char,
    input  logic               clear,
    lcd_refresh_ctrl_if.master eng,
    output logic               busy
);

    lcd_state_e    state;
    logic          line;
    logic [IW-1:0] idx;
    logic [1:0]    dirty;
    logic [1:0]    dirty_set;
    logic [1:0]    dirty_clr;
    logic          wr_ok;
    logic          start;
    logic          sel_line;
    logic [CW-1:0] rd_col;
    logic [7:0]    rd_char;

    assign wr_ok = wr_en && !clear && (int'(wr_col) < COLS);
    assign start = (state == IDLE) && init_done && (|dirty);

`ifdef LCD_REFRESH_RR_EN
    logic last_line;
    assign sel_line = (&dirty) ? ~last_line : dirty[1];
`else
    assign sel_line = ~dirty[0];
`endif

    always_comb begin
        dirty_set = '0;
        if (clear) begin
            dirty_set = 2'b11;
        end else if (wr_ok) begin
            dirty_set[wr_line] = 1'b1;
        end
    end

    always_comb begin
        dirty_clr = '0;
        if (start) begin
            dirty_clr[sel_line] = 1'b1;
        end
    end

    // A host write landing on the line being started wins, so that line is refreshed again.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dirty <= 2'b11;
        end else begin
            dirty <= (dirty & ~dirty_clr) | dirty_set;
        end
    end

    // idx has already been advanced past the command byte when a character is fetched.
    assign rd_col = CW'(idx - IW'(1));

    lcd_char_buffer #(.COLS(COLS)) u_buf (
        .clk     (clk),
        .rst     (rst),
        .clear   (clear),
        .we      (wr_ok),
        .we_line (wr_line),
        .we_col  (wr_col),
        .we_char (wr_char),
        .rd_line (line),
        .rd_col  (rd_col),
        .rd_char (rd_char)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            line          <= 1'b0;
            idx           <= '0;
            eng.ena_write <= 1'b0;
            eng.data      <= '0;
            eng.cmd_data  <= 1'b0;
            busy          <= 1'b0;
`ifdef LCD_REFRESH_RR_EN
            last_line     <= 1'b1;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        state         <= SEND;
                        line          <= sel_line;
                        idx           <= '0;
                        eng.ena_write <= 1'b1;
                        eng.data      <= sel_line ? LCD_CMD_LINE1 : LCD_CMD_LINE0;
                        eng.cmd_data  <= 1'b0;
                        busy          <= 1'b1;
                    end
                end
                SEND: begin
                    if (eng.done_write) begin
                        state         <= GAP;
                        idx           <= idx + IW'(1);
                        eng.ena_write <= 1'b0;
                    end
                end
                GAP: begin
                    if (idx <= IW'(COLS)) begin
                        state         <= SEND;
                        eng.ena_write <= 1'b1;
                        eng.data      <= rd_char;
                        eng.cmd_data  <= 1'b1;
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
`ifdef LCD_REFRESH_RR_EN
                        last_line <= line;
`endif
                    end
                end
                default: begin
                    state         <= IDLE;
                    eng.ena_write <= 1'b0;
                    busy          <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lcd_refresh_ctrl.sv
// Directed bench for lcd_refresh_ctrl: byte-engine model logs every transaction, tests compare
// the log against hand-derived sequences built from a shadow copy of the character buffer.
module tb_lcd_refresh_ctrl;
    import lcd_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic       init_done, wr_en, wr_line, clear, busy;
    logic [3:0] wr_col;
    logic [7:0] wr_char;

    logic       init_done2, wr_en2, wr_line2, clear2, busy2;
    logic [3:0] wr_col2;
    logic [7:0] wr_char2;

    lcd_refresh_ctrl_if bus ();
    lcd_refresh_ctrl_if bus2 ();

    lcd_refresh_ctrl #(.COLS(16)) dut (
        .clk(clk), .rst(rst), .init_done(init_done), .wr_en(wr_en), .wr_line(wr_line),
        .wr_col(wr_col), .wr_char(wr_char), .clear(clear), .eng(bus), .busy(busy)
    );

    lcd_refresh_ctrl #(.COLS(12)) dut2 (
        .clk(clk), .rst(rst), .init_done(init_done2), .wr_en(wr_en2), .wr_line(wr_line2),
        .wr_col(wr_col2), .wr_char(wr_char2), .clear(clear2), .eng(bus2), .busy(busy2)
    );

    int vectors = 0;
    int miscompares = 0;

    logic [8:0] log_q[$];
    logic [8:0] log2_q[$];
    logic [7:0] mbuf [2][16];

    // Engine model: completes each request one cycle after it is seen and logs {cmd_data, data}.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.done_write <= 1'b0;
        end else if (bus.ena_write && !bus.done_write) begin
            bus.done_write <= 1'b1;
            log_q.push_back({bus.cmd_data, bus.data});
        end else begin
            bus.done_write <= 1'b0;
        end
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            bus2.done_write <= 1'b0;
        end else if (bus2.ena_write && !bus2.done_write) begin
            bus2.done_write <= 1'b1;
            log2_q.push_back({bus2.cmd_data, bus2.data});
        end else begin
            bus2.done_write <= 1'b0;
        end
    end

    function automatic logic [8:0] exp_byte(input logic ln, input int k);
        if (k == 0) return {1'b0, (ln ? LCD_CMD_LINE1 : LCD_CMD_LINE0)};
        return {1'b1, mbuf[ln][k-1]};
    endfunction

    task automatic model_reset();
        for (int l = 0; l < 2; l++)
            for (int c = 0; c < 16; c++)
                mbuf[l][c] = LCD_SPACE;
    endtask

    task automatic wait_log(input int n, input int budget, output bit ok);
        int c = 0;
        while (log_q.size() < n && c < budget) begin
            @(negedge clk);
            c++;
        end
        ok = (log_q.size() >= n);
    endtask

    task automatic test_reset();
        bit ok;
        int hi = 0;
        @(negedge clk);
        rst = 1'b1;
        init_done = 1'b0;
        repeat (3) @(negedge clk);
        vectors++;
        if (bus.ena_write !== 1'b0 || busy !== 1'b0 || bus.data !== 8'h00 || bus.cmd_data !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_outputs: ena=%b busy=%b data=%h cmd=%b, required 0 0 00 0",
                     bus.ena_write, busy, bus.data, bus.cmd_data);
        end
        rst = 1'b0;
        log_q.delete();
        log2_q.delete();
        repeat (100) begin
            @(negedge clk);
            if (bus.ena_write) hi++;
        end
        vectors++;
        if (hi !== 0 || log_q.size() !== 0) begin
            miscompares++;
            $display("FAIL no_init_bytes: ena high %0d cycles, %0d bytes, required 0", hi, log_q.size());
        end
        init_done = 1'b1;
        wait_log(34, 3000, ok);
        vectors++;
        if (ok !== 1'b1) begin
            miscompares++;
            $display("FAIL init_refresh_timeout: got %0d bytes, required 34", log_q.size());
        end else begin
            for (int k = 0; k < 34; k++) begin
                vectors++;
                if (log_q[k] !== exp_byte(k >= 17, k % 17)) begin
                    miscompares++;
                    $display("FAIL init_byte[%0d]: got %h, required %h", k, log_q[k], exp_byte(k >= 17, k % 17));
                end
            end
        end
        repeat (3) @(negedge clk);
        vectors++;
        if (busy !== 1'b0 || log_q.size() !== 34) begin
            miscompares++;
            $display("FAIL init_idle_after: busy=%b bytes=%0d, required 0 and 34", busy, log_q.size());
        end
    endtask

    task automatic test_latency();
        bit ok;
        log_q.delete();
        @(negedge clk);
        wr_en = 1'b1; wr_line = 1'b1; wr_col = 4'd3; wr_char = 8'h41;
        mbuf[1][3] = 8'h41;
        @(posedge clk);
        #1;
        vectors++;
        if (bus.ena_write !== 1'b0) begin
            miscompares++;
            $display("FAIL latency_n1: ena=%b, required 0", bus.ena_write);
        end
        @(negedge clk);
        wr_en = 1'b0;
        @(posedge clk);
        #1;
        vectors++;
        if (bus.ena_write !== 1'b1 || busy !== 1'b1 || bus.data !== 8'hC0 || bus.cmd_data !== 1'b0) begin
            miscompares++;
            $display("FAIL latency_n2: ena=%b busy=%b data=%h cmd=%b, required 1 1 c0 0",
                     bus.ena_write, busy, bus.data, bus.cmd_data);
        end
        wait_log(17, 1000, ok);
        vectors++;
        if (ok !== 1'b1) begin
            miscompares++;
            $display("FAIL line1_timeout: got %0d bytes, required 17", log_q.size());
        end else begin
            for (int k = 0; k < 17; k++) begin
                vectors++;
                if (log_q[k] !== exp_byte(1'b1, k)) begin
                    miscompares++;
                    $display("FAIL line1_byte[%0d]: got %h, required %h", k, log_q[k], exp_byte(1'b1, k));
                end
            end
        end
        repeat (80) @(negedge clk);
        vectors++;
        if (log_q.size() !== 17 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL line0_not_sent: bytes=%0d busy=%b, required 17 and 0", log_q.size(), busy);
        end
    endtask

    task automatic test_midline_write();
        bit ok;
        int n = 0;
        log_q.delete();
        @(negedge clk);
        wr_en = 1'b1; wr_line = 1'b0; wr_col = 4'd0; wr_char = LCD_SPACE;
        @(negedge clk);
        wr_en = 1'b0;
        while (!(log_q.size() == 5 && bus.ena_write) && n < 500) begin
            @(negedge clk);
            n++;
        end
        vectors++;
        if (!(log_q.size() == 5 && bus.ena_write)) begin
            miscompares++;
            $display("FAIL midline_reach_idx5: bytes=%0d ena=%b, required 5 and 1", log_q.size(), bus.ena_write);
        end
        wr_en = 1'b1; wr_line = 1'b0; wr_col = 4'd15; wr_char = 8'h42;
        mbuf[0][15] = 8'h42;
        @(negedge clk);
        wr_en = 1'b0;
        wait_log(34, 2000, ok);
        vectors++;
        if (ok !== 1'b1) begin
            miscompares++;
            $display("FAIL midline_timeout: got %0d bytes, required 34", log_q.size());
        end else begin
            for (int k = 0; k < 34; k++) begin
                vectors++;
                if (log_q[k] !== exp_byte(1'b0, k % 17)) begin
                    miscompares++;
                    $display("FAIL midline_byte[%0d]: got %h, required %h", k, log_q[k], exp_byte(1'b0, k % 17));
                end
            end
        end
        repeat (60) @(negedge clk);
        vectors++;
        if (log_q.size() !== 34) begin
            miscompares++;
            $display("FAIL midline_extra: bytes=%0d, required 34", log_q.size());
        end
    endtask

    task automatic test_clear_collide();
        bit ok;
        logic first;
`ifdef LCD_REFRESH_RR_EN
        first = 1'b1;
`else
        first = 1'b0;
`endif
        log_q.delete();
        @(negedge clk);
        wr_en = 1'b1; wr_line = 1'b0; wr_col = 4'd1; wr_char = 8'h44; clear = 1'b1;
        model_reset();
        @(negedge clk);
        wr_en = 1'b0; clear = 1'b0;
        wait_log(34, 3000, ok);
        vectors++;
        if (ok !== 1'b1) begin
            miscompares++;
            $display("FAIL clear_timeout: got %0d bytes, required 34", log_q.size());
        end else begin
            for (int k = 0; k < 34; k++) begin
                logic ln;
                ln = (k < 17) ? first : ~first;
                vectors++;
                if (log_q[k] !== exp_byte(ln, k % 17)) begin
                    miscompares++;
                    $display("FAIL clear_byte[%0d]: got %h, required %h", k, log_q[k], exp_byte(ln, k % 17));
                end
            end
        end
        repeat (60) @(negedge clk);
        vectors++;
        if (log_q.size() !== 34 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL clear_extra: bytes=%0d busy=%b, required 34 and 0", log_q.size(), busy);
        end
    endtask

    task automatic test_bad_col();
        int n = 0;
        int hi = 0;
        while ((busy2 !== 1'b0) && n < 500) begin
            @(negedge clk);
            n++;
        end
        vectors++;
        if (busy2 !== 1'b0) begin
            miscompares++;
            $display("FAIL badcol_idle: busy2=%b, required 0", busy2);
        end
        log2_q.delete();
        wr_en2 = 1'b1; wr_line2 = 1'b0; wr_col2 = 4'd13; wr_char2 = 8'h99;
        @(negedge clk);
        wr_en2 = 1'b0;
        repeat (60) begin
            @(negedge clk);
            if (bus2.ena_write) hi++;
        end
        vectors++;
        if (hi !== 0 || log2_q.size() !== 0) begin
            miscompares++;
            $display("FAIL badcol_ignored: ena high %0d cycles, %0d bytes, required 0", hi, log2_q.size());
        end
        wr_en2 = 1'b1; wr_line2 = 1'b1; wr_col2 = 4'd11; wr_char2 = 8'h5A;
        @(negedge clk);
        wr_en2 = 1'b0;
        n = 0;
        while (log2_q.size() < 13 && n < 500) begin
            @(negedge clk);
            n++;
        end
        vectors++;
        if (log2_q.size() < 13) begin
            miscompares++;
            $display("FAIL lastcol_timeout: got %0d bytes, required 13", log2_q.size());
        end else if (log2_q[0] !== 9'h0C0 || log2_q[11] !== 9'h120 || log2_q[12] !== 9'h15A) begin
            miscompares++;
            $display("FAIL lastcol_bytes: got %h %h %h, required 0c0 120 15a", log2_q[0], log2_q[11], log2_q[12]);
        end
    endtask

    task automatic test_rst_midline();
        bit ok;
        int n = 0;
        log_q.delete();
        @(negedge clk);
        wr_en = 1'b1; wr_line = 1'b0; wr_col = 4'd2; wr_char = 8'h37;
        mbuf[0][2] = 8'h37;
        @(negedge clk);
        wr_en = 1'b0;
        while (!(log_q.size() == 8 && bus.ena_write) && n < 500) begin
            @(negedge clk);
            n++;
        end
        rst = 1'b1;
        #1;
        vectors++;
        if (bus.ena_write !== 1'b0 || busy !== 1'b0 || n >= 500) begin
            miscompares++;
            $display("FAIL rst_midline: ena=%b busy=%b waited=%0d, required 0 0 <500", bus.ena_write, busy, n);
        end
        model_reset();
        log_q.delete();
        @(negedge clk);
        rst = 1'b0;
        wait_log(34, 3000, ok);
        vectors++;
        if (ok !== 1'b1) begin
            miscompares++;
            $display("FAIL rst_restart_timeout: got %0d bytes, required 34", log_q.size());
        end else begin
            for (int k = 0; k < 34; k++) begin
                vectors++;
                if (log_q[k] !== exp_byte(k >= 17, k % 17)) begin
                    miscompares++;
                    $display("FAIL rst_restart_byte[%0d]: got %h, required %h", k, log_q[k], exp_byte(k >= 17, k % 17));
                end
            end
        end
    endtask

    task automatic test_round_robin();
        int n = 0;
        int cmds = 0;
        int j = 0;
        logic [7:0] exp_cmd [4];
`ifdef LCD_REFRESH_RR_EN
        exp_cmd = '{8'h80, 8'hC0, 8'h80, 8'hC0};
`else
        exp_cmd = '{8'h80, 8'h80, 8'h80, 8'h80};
`endif
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        log_q.delete();
        @(negedge clk);
        rst = 1'b0;
        while (cmds < 4 && n < 3000) begin
            wr_en = 1'b1; wr_line = n[0]; wr_col = 4'd0; wr_char = LCD_SPACE;
            @(negedge clk);
            n++;
            cmds = 0;
            foreach (log_q[i]) if (!log_q[i][8]) cmds++;
        end
        wr_en = 1'b0;
        vectors++;
        if (cmds < 4) begin
            miscompares++;
            $display("FAIL rr_timeout: got %0d commands, required 4", cmds);
        end else begin
            foreach (log_q[i]) begin
                if (!log_q[i][8] && j < 4) begin
                    vectors++;
                    if (log_q[i][7:0] !== exp_cmd[j]) begin
                        miscompares++;
                        $display("FAIL rr_cmd[%0d]: got %h, required %h", j, log_q[i][7:0], exp_cmd[j]);
                    end
                    j++;
                end
            end
        end
    endtask

    initial begin
        init_done = 1'b0; wr_en = 1'b0; wr_line = 1'b0; wr_col = '0; wr_char = '0; clear = 1'b0;
        init_done2 = 1'b1; wr_en2 = 1'b0; wr_line2 = 1'b0; wr_col2 = '0; wr_char2 = '0; clear2 = 1'b0;
        model_reset();
        test_reset();
        test_latency();
        test_midline_write();
        test_clear_collide();
        test_bad_col();
        test_rst_midline();
        test_round_robin();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
